// File: rtl/riscv_hazard_scoreboard_pkg.sv
// Shared types, bypass codes and the result-readiness matrix for the hazard scoreboard.
// Optional build macro used by the top: RISCV_SCOREBOARD_PERF_EN.
package riscv_ScoreboardPkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_W     = $clog2(NUM_REGS);
  localparam int NUM_TRACK = 5;

  localparam logic [2:0] BYP_RF = 3'd0;
  localparam logic [2:0] BYP_X  = 3'd1;
  localparam logic [2:0] BYP_M  = 3'd2;
  localparam logic [2:0] BYP_X2 = 3'd3;
  localparam logic [2:0] BYP_X3 = 3'd4;
  localparam logic [2:0] BYP_W  = 3'd5;

  localparam logic [1:0] LAT_ALU = 2'd0;
  localparam logic [1:0] LAT_LD  = 2'd1;
  localparam logic [1:0] LAT_MD  = 2'd2;

  // Tracked stage index: 0 X, 1 M, 2 X2, 3 X3, 4 W
  localparam logic [2:0] ST_X  = 3'd0;
  localparam logic [2:0] ST_M  = 3'd1;
  localparam logic [2:0] ST_X2 = 3'd2;
  localparam logic [2:0] ST_X3 = 3'd3;
  localparam logic [2:0] ST_W  = 3'd4;

  typedef struct packed {
    logic             val;
    logic             wen;
    logic [REG_W-1:0] rd;
    logic [1:0]       lat;
  } entry_t;

  // Reserved latency class 3 falls through to the muldiv row.
  function automatic logic ready(input logic [1:0] lat, input logic [2:0] stage);
    case (lat)
      LAT_ALU: ready = 1'b1;
      LAT_LD:  ready = (stage != ST_X);
      default: ready = (stage == ST_X3) || (stage == ST_W);
    endcase
  endfunction

endpackage

// File: rtl/riscv_hazard_scoreboard_src_check.sv
// One decode source operand: finds the youngest matching in-flight writer and
// returns its bypass select, or flags a RAW hazard if that result is not ready yet.
module riscv_scoreboard_src_check
  import riscv_ScoreboardPkg::*;
(
  input  logic [REG_W-1:0]           src,
  input  logic                       src_en,
  input  logic [NUM_TRACK-1:0]       wr_val,
  input  logic [REG_W*NUM_TRACK-1:0] wr_rd,
  input  logic [2*NUM_TRACK-1:0]     wr_lat,
  output logic [2:0]                 sel,
  output logic                       hazard
);

  logic found;

  // Scanning X first and latching the first hit keeps an older result from
  // ever being forwarded past a younger writer of the same register.
  always_comb begin
    sel    = BYP_RF;
    hazard = 1'b0;
    found  = 1'b0;
    if (src_en && (src != '0)) begin
      for (int s = 0; s < NUM_TRACK; s++) begin
        if (!found && wr_val[s] && (wr_rd[REG_W*s +: REG_W] == src)) begin
          found = 1'b1;
          if (ready(wr_lat[2*s +: 2], 3'(s)))
            sel = BYP_X + 3'(s);
          else
            hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/riscv_hazard_scoreboard.sv
// Shadow pipeline of register writers in X..W driving decode bypass selects and RAW stall.
// Build macro RISCV_SCOREBOARD_PERF_EN adds raw-stall and bypass event counters.
module riscv_hazard_scoreboard
  import riscv_ScoreboardPkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_val_Dhl,
  input  logic [REG_W-1:0] dec_rs1_Dhl,
  input  logic             dec_rs1_en_Dhl,
  input  logic [REG_W-1:0] dec_rs2_Dhl,
  input  logic             dec_rs2_en_Dhl,
  input  logic [REG_W-1:0] dec_rd_Dhl,
  input  logic             dec_rd_en_Dhl,
  input  logic [1:0]       dec_lat_Dhl,
  input  logic             squash_Dhl,
  input  logic             stall_ext_Dhl,
  input  logic             stall_Xhl,
  input  logic             stall_Mhl,
  input  logic             stall_X2hl,
  input  logic             stall_X3hl,
  input  logic             stall_Whl,
  output logic [2:0]       rdata0_byp_mux_sel_Dhl,
  output logic [2:0]       rdata1_byp_mux_sel_Dhl,
  output logic             raw_stall_Dhl,
`ifdef RISCV_SCOREBOARD_PERF_EN
  output logic [31:0]      perf_raw_stall_cnt,
  output logic [31:0]      perf_bypass_cnt,
`endif
  output logic             stall_Dhl_total
);

  entry_t                     stg [NUM_TRACK];
  logic [NUM_TRACK-1:0]       stall_vec;
  logic [NUM_TRACK-1:0]       wr_val;
  logic [REG_W*NUM_TRACK-1:0] wr_rd;
  logic [2*NUM_TRACK-1:0]     wr_lat;
  logic [2:0]                 sel0, sel1;
  logic                       hazard0, hazard1;
  logic                       raw_int, stall_d_int;

  assign stall_vec = {stall_Whl, stall_X3hl, stall_X2hl, stall_Mhl, stall_Xhl};

  always_comb begin
    for (int s = 0; s < NUM_TRACK; s++) begin
      wr_val[s]                  = stg[s].val && stg[s].wen && (stg[s].rd != '0);
      wr_rd[REG_W*s +: REG_W]    = stg[s].rd;
      wr_lat[2*s +: 2]           = stg[s].lat;
    end
  end

  riscv_scoreboard_src_check u_src0 (
    .src    (dec_rs1_Dhl),
    .src_en (dec_rs1_en_Dhl),
    .wr_val (wr_val),
    .wr_rd  (wr_rd),
    .wr_lat (wr_lat),
    .sel    (sel0),
    .hazard (hazard0)
  );

  riscv_scoreboard_src_check u_src1 (
    .src    (dec_rs2_Dhl),
    .src_en (dec_rs2_en_Dhl),
    .wr_val (wr_val),
    .wr_rd  (wr_rd),
    .wr_lat (wr_lat),
    .sel    (sel1),
    .hazard (hazard1)
  );

  // Squash is deliberately not folded in here; the control unit ranks it above the stall.
  assign raw_int     = dec_val_Dhl && (hazard0 || hazard1);
  assign stall_d_int = raw_int || stall_ext_Dhl;

  assign rdata0_byp_mux_sel_Dhl = reset ? BYP_RF : sel0;
  assign rdata1_byp_mux_sel_Dhl = reset ? BYP_RF : sel1;
  assign raw_stall_Dhl          = !reset && raw_int;
  assign stall_Dhl_total        = !reset && stall_d_int;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_TRACK; s++)
        stg[s].val <= 1'b0;
    end else begin
      if (!stall_vec[0])
        stg[0] <= '{val: dec_val_Dhl && !stall_d_int && !squash_Dhl,
                    wen: dec_rd_en_Dhl, rd: dec_rd_Dhl, lat: dec_lat_Dhl};
      // A stalled upstream stage leaves a bubble in a free downstream stage.
      for (int s = 1; s < NUM_TRACK; s++) begin
        if (!stall_vec[s])
          stg[s] <= '{val: stg[s-1].val && !stall_vec[s-1],
                      wen: stg[s-1].wen, rd: stg[s-1].rd, lat: stg[s-1].lat};
      end
    end
  end

`ifdef RISCV_SCOREBOARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_raw_stall_cnt <= '0;
      perf_bypass_cnt    <= '0;
    end else begin
      if (raw_int)
        perf_raw_stall_cnt <= perf_raw_stall_cnt + 32'd1;
      if (dec_val_Dhl && !stall_d_int && !squash_Dhl && ((sel0 != BYP_RF) || (sel1 != BYP_RF)))
        perf_bypass_cnt <= perf_bypass_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// Directed-vector bench for riscv_hazard_scoreboard with hand-computed expectations.
module tb_riscv_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_val_Dhl;
  logic [4:0] dec_rs1_Dhl, dec_rs2_Dhl, dec_rd_Dhl;
  logic       dec_rs1_en_Dhl, dec_rs2_en_Dhl, dec_rd_en_Dhl;
  logic [1:0] dec_lat_Dhl;
  logic       squash_Dhl, stall_ext_Dhl;
  logic       stall_Xhl, stall_Mhl, stall_X2hl, stall_X3hl, stall_Whl;
  logic [2:0] rdata0_byp_mux_sel_Dhl, rdata1_byp_mux_sel_Dhl;
  logic       raw_stall_Dhl, stall_Dhl_total;
`ifdef RISCV_SCOREBOARD_PERF_EN
  logic [31:0] perf_raw_stall_cnt, perf_bypass_cnt;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int n;

  always #5 clk = ~clk;

  riscv_hazard_scoreboard dut (
    .clk                    (clk),
    .reset                  (reset),
    .dec_val_Dhl            (dec_val_Dhl),
    .dec_rs1_Dhl            (dec_rs1_Dhl),
    .dec_rs1_en_Dhl         (dec_rs1_en_Dhl),
    .dec_rs2_Dhl            (dec_rs2_Dhl),
    .dec_rs2_en_Dhl         (dec_rs2_en_Dhl),
    .dec_rd_Dhl             (dec_rd_Dhl),
    .dec_rd_en_Dhl          (dec_rd_en_Dhl),
    .dec_lat_Dhl            (dec_lat_Dhl),
    .squash_Dhl             (squash_Dhl),
    .stall_ext_Dhl          (stall_ext_Dhl),
    .stall_Xhl              (stall_Xhl),
    .stall_Mhl              (stall_Mhl),
    .stall_X2hl             (stall_X2hl),
    .stall_X3hl             (stall_X3hl),
    .stall_Whl              (stall_Whl),
    .rdata0_byp_mux_sel_Dhl (rdata0_byp_mux_sel_Dhl),
    .rdata1_byp_mux_sel_Dhl (rdata1_byp_mux_sel_Dhl),
    .raw_stall_Dhl          (raw_stall_Dhl),
`ifdef RISCV_SCOREBOARD_PERF_EN
    .perf_raw_stall_cnt     (perf_raw_stall_cnt),
    .perf_bypass_cnt        (perf_bypass_cnt),
`endif
    .stall_Dhl_total        (stall_Dhl_total)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs1, input logic e1,
                       input logic [4:0] rs2, input logic e2,
                       input logic [4:0] rd, input logic rde, input logic [1:0] lat);
    dec_val_Dhl    = v;
    dec_rs1_Dhl    = rs1;  dec_rs1_en_Dhl = e1;
    dec_rs2_Dhl    = rs2;  dec_rs2_en_Dhl = e2;
    dec_rd_Dhl     = rd;   dec_rd_en_Dhl  = rde;
    dec_lat_Dhl    = lat;
    squash_Dhl     = 1'b0;
    stall_ext_Dhl  = 1'b0;
  endtask

  task automatic drain();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) tick();
  endtask

  task automatic check_outs(input string tag, input int s0, input int s1, input int raw);
    check_val({tag, ".sel0"}, int'(rdata0_byp_mux_sel_Dhl), s0);
    check_val({tag, ".sel1"}, int'(rdata1_byp_mux_sel_Dhl), s1);
    check_val({tag, ".raw"},  int'(raw_stall_Dhl), raw);
  endtask

  initial begin
    reset = 1'b1;
    stall_Xhl = 0; stall_Mhl = 0; stall_X2hl = 0; stall_X3hl = 0; stall_Whl = 0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    check_outs("rst", 0, 0, 0);
    check_val("rst.total", int'(stall_Dhl_total), 0);
`ifdef RISCV_SCOREBOARD_PERF_EN
    check_val("rst.perf_raw", int'(perf_raw_stall_cnt), 0);
    check_val("rst.perf_byp", int'(perf_bypass_cnt), 0);
`endif
    reset = 1'b0;
    tick();

    // ALU add x5, then reader of x5 that writes x6, then reader of x5/x6
    set_d(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    set_d(1, 5, 1, 0, 0, 6, 1, 0);
    #1 check_outs("alu_x", 1, 0, 0);
    tick();
    set_d(1, 5, 1, 6, 1, 0, 0, 0);
    #1 check_outs("alu_m", 2, 1, 0);
    drain();

    // Load x7 -> one stall cycle then M bypass on source 2
    set_d(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    set_d(1, 0, 0, 7, 1, 0, 0, 0);
    #1 check_outs("ld_x", 0, 0, 1);
    check_val("ld_x.total", int'(stall_Dhl_total), 1);
    tick();
    #1 check_outs("ld_m", 0, 2, 0);
    check_val("ld_m.total", int'(stall_Dhl_total), 0);
    drain();

    // Muldiv x9 -> three stall cycles, then X3, then W for a later reader
    set_d(1, 0, 0, 0, 0, 9, 1, 2);
    tick();
    set_d(1, 9, 1, 0, 0, 0, 0, 0);
    #1;
    n = 0;
    while (raw_stall_Dhl === 1'b1 && n < 10) begin
      n++;
      tick();
      #1;
    end
    check_val("md.stall_cycles", n, 3);
    check_val("md.sel0", int'(rdata0_byp_mux_sel_Dhl), 4);
    tick();
    set_d(1, 0, 0, 9, 1, 0, 0, 0);
    #1 check_outs("md_w", 0, 5, 0);
    drain();

    // add x3, two bubbles, lw x3: younger non-ready lw shadows ready add in X3
    set_d(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    set_d(1, 0, 0, 0, 0, 3, 1, 1);
    tick();
    set_d(1, 3, 1, 0, 0, 0, 0, 0);
    #1 check_outs("shadow_x", 0, 0, 1);
    tick();
    #1 check_outs("shadow_m", 2, 0, 0);
    drain();

    // rs_en=0, rd_en=0 and x0 handling
    set_d(1, 0, 0, 0, 0, 8, 1, 0);
    tick();
    set_d(1, 8, 0, 0, 0, 10, 0, 0);
    #1 check_outs("rs_en0", 0, 0, 0);
    tick();
    set_d(1, 8, 1, 10, 1, 0, 1, 1);
    #1 check_outs("rd_en0", 2, 0, 0);
    tick();
    set_d(1, 0, 1, 0, 1, 0, 0, 0);
    #1 check_outs("x0", 0, 0, 0);
    drain();

    // Squash kills the D instruction before it reaches X
    set_d(1, 0, 0, 0, 0, 11, 1, 1);
    squash_Dhl = 1'b1;
    tick();
    set_d(1, 11, 1, 0, 0, 0, 0, 0);
    #1 check_outs("squash", 0, 0, 0);
    drain();

    // External stall with squash inserts a bubble
    set_d(1, 0, 0, 0, 0, 12, 1, 1);
    squash_Dhl = 1'b1;
    stall_ext_Dhl = 1'b1;
    #1 check_val("ext.total", int'(stall_Dhl_total), 1);
    check_val("ext.raw", int'(raw_stall_Dhl), 0);
    tick();
    set_d(1, 12, 1, 0, 0, 0, 0, 0);
    #1 check_outs("ext_bubble", 0, 0, 0);
    drain();

    // stall_Xhl holds a load in X for an extra cycle
    set_d(1, 0, 0, 0, 0, 13, 1, 1);
    tick();
    set_d(1, 13, 1, 0, 0, 0, 0, 0);
    stall_Xhl = 1'b1;
    #1 check_outs("xhold0", 0, 0, 1);
    tick();
    #1 check_outs("xhold1", 0, 0, 1);
    stall_Xhl = 1'b0;
    tick();
    #1 check_outs("xhold_rel", 2, 0, 0);
    drain();

    // Mid-operation reset with three valid writers
    set_d(1, 0, 0, 0, 0, 14, 1, 0);
    tick();
    set_d(1, 0, 0, 0, 0, 15, 1, 0);
    tick();
    set_d(1, 0, 0, 0, 0, 16, 1, 1);
    tick();
    set_d(1, 14, 1, 16, 1, 0, 0, 0);
    #1 check_outs("prerst", 3, 0, 1);
    reset = 1'b1;
    #1 check_outs("inrst", 0, 0, 0);
    check_val("inrst.total", int'(stall_Dhl_total), 0);
    tick();
    reset = 1'b0;
    set_d(1, 14, 1, 15, 1, 0, 0, 0);
    #1 check_outs("postrst", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
